// File: rtl/countdown_sec_bcd.sv
// countdown_sec_bcd: two-digit BCD seconds countdown driven by a one-second tick
module countdown_sec_bcd #(
    parameter logic [3:0] DEFAULT_TENS = 4'd3,
    parameter logic [3:0] DEFAULT_ONES = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    input  logic       tick,
    output logic       timer_en,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       done,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    localparam logic [3:0] RST_TENS = (DEFAULT_TENS > 4'd9) ? 4'd9 : DEFAULT_TENS;
    localparam logic [3:0] RST_ONES = (DEFAULT_ONES > 4'd9) ? 4'd9 : DEFAULT_ONES;

    state_t     state, state_n;
    logic [3:0] tens_n, ones_n, dec_tens, dec_ones;
    logic       timeout_n, dec_zero;

    function automatic logic [3:0] clamp(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign dec_tens = (ones == 4'd0) ? tens - 4'd1 : tens;
    assign dec_ones = (ones == 4'd0) ? 4'd9 : ones - 4'd1;
    assign dec_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0);

    // next-state and next-digit logic; load outranks everything outside RUN
    always_comb begin
        state_n   = state;
        tens_n    = tens;
        ones_n    = ones;
        timeout_n = 1'b0;
        if (load && state != RUN) begin
            state_n = IDLE;
            tens_n  = clamp(load_tens);
            ones_n  = clamp(load_ones);
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (tens == 4'd0 && ones == 4'd0) begin
                        state_n   = EXPIRED;
                        timeout_n = 1'b1;
                    end else begin
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        tens_n = dec_tens;
                        ones_n = dec_ones;
                    end
                    if (tick && dec_zero) begin
                        state_n   = EXPIRED;
                        timeout_n = 1'b1;
                    end else if (pause) begin
                        state_n = PAUSED;
                    end
                end
                PAUSED: if (start) state_n = RUN;
                EXPIRED: begin
                    tens_n = 4'd0;
                    ones_n = 4'd0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // state, digits and decoded outputs all registered from next-state values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tens     <= RST_TENS;
            ones     <= RST_ONES;
            timer_en <= 1'b0;
            running  <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            tens     <= tens_n;
            ones     <= ones_n;
            timer_en <= (state_n == RUN);
            running  <= (state_n == RUN);
            done     <= (state_n == EXPIRED);
            timeout  <= timeout_n;
        end
    end

endmodule

// File: tb/tb_countdown_sec_bcd.sv
// tb_countdown_sec_bcd: directed self-checking bench for countdown_sec_bcd
module tb_countdown_sec_bcd;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0, start = 1'b0, pause = 1'b0, tick = 1'b0;
    logic [3:0] load_tens = 4'd0, load_ones = 4'd0;
    logic       timer_en, running, done, timeout;
    logic [3:0] tens, ones;
    logic [7:0] bcd;
    int         checks = 0, errors = 0;

    assign bcd = {tens, ones};

    countdown_sec_bcd dut (
        .clk(clk), .rst(rst), .load(load), .load_tens(load_tens), .load_ones(load_ones),
        .start(start), .pause(pause), .tick(tick), .timer_en(timer_en),
        .tens(tens), .ones(ones), .running(running), .done(done), .timeout(timeout)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock with the given inputs, then sample 1 time unit after the edge
    task automatic cyc(input logic l, input logic [3:0] lt, input logic [3:0] lo,
                       input logic s, input logic p, input logic t);
        @(negedge clk);
        load = l; load_tens = lt; load_ones = lo; start = s; pause = p; tick = t;
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_bcd", bcd, 8'h30);
        chk("rst_done", 8'(done), 8'h0);
        chk("rst_ten", 8'(timer_en), 8'h0);
        chk("rst_run", 8'(running), 8'h0);
        chk("rst_to", 8'(timeout), 8'h0);

        cyc(1, 4'd1, 4'd2, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("idle_tick", bcd, 8'h12);
        chk("idle_ten", 8'(timer_en), 8'h0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("start_run", 8'(running), 8'h1);
        chk("start_ten", 8'(timer_en), 8'h1);
        idle(23); cyc(0, 0, 0, 0, 0, 1);
        chk("t1", bcd, 8'h11);
        idle(23); cyc(0, 0, 0, 0, 0, 1);
        chk("t2", bcd, 8'h10);
        idle(23); cyc(0, 0, 0, 0, 0, 1);
        chk("borrow", bcd, 8'h09);
        cyc(1, 4'd4, 4'd5, 0, 0, 0);
        chk("run_load", bcd, 8'h09);
        chk("run_load_run", 8'(running), 8'h1);

        @(negedge clk) rst = 1'b0;
        #1;
        chk("arst_bcd", bcd, 8'h30);
        chk("arst_run", 8'(running), 8'h0);
        chk("arst_ten", 8'(timer_en), 8'h0);
        chk("arst_to", 8'(timeout), 8'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        cyc(1, 4'd0, 4'd2, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("exp_01", bcd, 8'h01);
        chk("exp_01_to", 8'(timeout), 8'h0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("exp_00", bcd, 8'h00);
        chk("exp_to", 8'(timeout), 8'h1);
        chk("exp_done", 8'(done), 8'h1);
        chk("exp_ten", 8'(timer_en), 8'h0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("exp_to_once", 8'(timeout), 8'h0);
        cyc(0, 0, 0, 1, 1, 1);
        chk("exp_hold", bcd, 8'h00);
        chk("exp_hold_to", 8'(timeout), 8'h0);
        chk("exp_hold_done", 8'(done), 8'h1);
        cyc(1, 4'd0, 4'd7, 0, 0, 0);
        chk("exp_load", bcd, 8'h07);
        chk("exp_load_done", 8'(done), 8'h0);

        cyc(1, 4'd0, 4'd5, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("p_04", bcd, 8'h04);
        cyc(0, 0, 0, 0, 1, 1);
        chk("p_03", bcd, 8'h03);
        chk("p_run", 8'(running), 8'h0);
        chk("p_ten", 8'(timer_en), 8'h0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1);
        chk("p_hold", bcd, 8'h03);
        cyc(0, 0, 0, 1, 0, 0);
        chk("resume_run", 8'(running), 8'h1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("resume_02", bcd, 8'h02);

        cyc(0, 0, 0, 0, 1, 0);
        chk("p2_run", 8'(running), 8'h0);
        cyc(1, 4'hC, 4'hB, 0, 0, 0);
        chk("clamp", bcd, 8'h99);
        chk("clamp_done", 8'(done), 8'h0);
        cyc(1, 4'd9, 4'd9, 1, 0, 0);
        chk("ld_start_run", 8'(running), 8'h0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("ld_start_idle", bcd, 8'h99);

        cyc(1, 4'd0, 4'd0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("z_to", 8'(timeout), 8'h1);
        chk("z_done", 8'(done), 8'h1);
        chk("z_ten", 8'(timer_en), 8'h0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("z_to_once", 8'(timeout), 8'h0);
        chk("z_ten2", 8'(timer_en), 8'h0);
        chk("z_bcd", bcd, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
